alarm_trigger: RTL and testbench
================================

# alarm_trigger

Alarm-side producer of `blink_signal` for the LED blinker, and of `ringing`/`snoozing` for the display and buzzer. It compares the running time against the programmed alarm time and enters a ringing state on a match. It handles stop, snooze with a bounded snooze count, and automatic ring timeout, all paced by the timekeeper's 1 Hz tick. It sits between the timekeeping core and the LED/buzzer output blocks.

## Interface
- `RING_TIMEOUT_SEC`, 60: seconds of ringing before automatic return to idle.
- `SNOOZE_SEC`, 300: seconds of silence per snooze.
- `MAX_SNOOZES`, 3: snoozes allowed per alarm event (1..3).
- `clk`  in  1  system clock, 50 MHz.
- `rst_n`  in  1  asynchronous, active-low reset.
- `tick_1hz`  in  1  one-cycle pulse per second from the timekeeper.
- `cur_hour`  in  5  current hour, binary 0–23.
- `cur_min`  in  6  current minute, binary 0–59.
- `alarm_hour`  in  5  programmed alarm hour, binary 0–23.
- `alarm_min`  in  6  programmed alarm minute, binary 0–59.
- `alarm_en`  in  1  alarm armed (level).
- `stop_btn`  in  1  debounced, synchronized, active-high level; rising edge acts.
- `snooze_btn`  in  1  debounced, synchronized, active-high level; rising edge acts.
- `blink_signal`  out  1  high while ringing; drives the LED blinker.
- `ringing`  out  1  registered, state == RINGING.
- `snoozing`  out  1  registered, state == SNOOZE.
- `snooze_count`  out  2  snoozes used in the current event.

## Operation
- `match` = `alarm_en` & (`cur_hour` == `alarm_hour`) & (`cur_min` == `alarm_min`).
- A trigger is a rising edge of `match`. Enabling the alarm inside the matching minute fires it.
- States: IDLE, RINGING, SNOOZE. Each state keeps a seconds counter `sec_cnt`.
- IDLE:
  - On a trigger, go to RINGING.
  - Clear `sec_cnt` and `snooze_count`.
- RINGING:
  - A stop edge goes to IDLE.
  - A snooze edge with `snooze_count` < `MAX_SNOOZES` goes to SNOOZE, increments `snooze_count` and clears `sec_cnt`.
  - A snooze edge at the limit is ignored; ringing continues.
  - Each tick increments `sec_cnt`. The tick that makes `sec_cnt` reach `RING_TIMEOUT_SEC` goes to IDLE.
- SNOOZE:
  - A stop edge goes to IDLE.
  - Each tick increments `sec_cnt`. Reaching `SNOOZE_SEC` goes to RINGING, clears `sec_cnt` and keeps `snooze_count`.
  - A snooze edge is ignored.
- `alarm_en` low in RINGING or SNOOZE goes to IDLE on the next edge.
- Same-cycle priority: `alarm_en` low > stop > snooze > tick/timeout.
- Triggers outside IDLE are ignored. A new match edge (next day) is required to re-fire.
- `snooze_count` returns to 0 only when IDLE takes a new trigger. It holds its value in IDLE for display.
- `sec_cnt` width is $clog2(max(`RING_TIMEOUT_SEC`, `SNOOZE_SEC`)+1). It never wraps because the terminal count always forces a transition.

## Timing
- Reset values:
  - State IDLE; `blink_signal`, `ringing`, `snoozing`, `snooze_count` and `sec_cnt` are 0.
  - Edge-detector history registers reset to 1. Releasing reset while in the matching minute, or with a button held, does not fire.
- All outputs are registered. Inputs at cycle N: a trigger sampled at cycle N shows `ringing` = `blink_signal` = 1 at N+1.
- Button edges likewise take effect one cycle after the sampled rising edge.
- A tick in the same cycle as a state entry is not counted. Counting starts with the next tick.
- Timeout: the state changes on the cycle after the `RING_TIMEOUT_SEC`-th counted tick is sampled.
- Reset asserted mid-ring or mid-snooze forces IDLE immediately (asynchronously) and drops all outputs.

## Structure
- Shared package `alarm_pkg`:
  - state encoding constants IDLE=2'd0, RINGING=2'd1, SNOOZE=2'd2;
  - `HOUR_W`=5 and `MIN_W`=6 for reuse by the timekeeper and the set logic.
- One sub-module, `rise_detect`: 1-bit rising-edge detector with a reset-value parameter. It is instantiated three times, for `match`, `stop_btn` and `snooze_btn`.
- The FSM, `sec_cnt` and `snooze_count` live in `alarm_trigger`.

## Test plan
Bench parameters: `RING_TIMEOUT_SEC`=4, `SNOOZE_SEC`=3, `MAX_SNOOZES`=2.
- **Trigger and stop:** alarm 07:30, `alarm_en`=1; time steps 07:29→07:30.
  - `ringing`/`blink_signal` go high 1 cycle later.
  - A stop pulse returns to IDLE, all outputs 0, `snooze_count`=0.
- **Timeout:** in RINGING with no buttons, issue 4 ticks.
  - RINGING holds through 3 ticks and goes to IDLE 1 cycle after the 4th.
- **Snooze limit:** snooze → `snoozing`=1, `snooze_count`=1.
  - After 3 ticks, RINGING again.
  - Snooze → `snooze_count`=2; after 3 ticks, ringing.
  - A third snooze is ignored: `ringing` stays 1, `snooze_count` stays 2.
- **Simultaneous events:**
  - stop and snooze in the same cycle → IDLE;
  - tick plus snooze on the 4th ringing second → SNOOZE, not IDLE;
  - `alarm_en` dropped together with snooze → IDLE.
- **Reset cases:**
  - release `rst_n` while time = alarm time with `stop_btn` held → stays IDLE;
  - assert `rst_n` low mid-SNOOZE → outputs 0 asynchronously;
  - after release, the match edge on the next day's minute rings.
- **Arming inside the matching minute:** 07:30 with `alarm_en` raised at 07:30:20 → ringing 1 cycle later.
  - After a stop, still in 07:30, no re-fire.

Source files
------------

// File: rtl/alarm_pkg.sv
// Shared alarm definitions: FSM state encoding and time-field widths used by
// the alarm, timekeeper and set logic.
package alarm_pkg;

   localparam int HOUR_W = 5;
   localparam int MIN_W  = 6;

   typedef logic [1:0] state_t;

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] RINGING = 2'd1;
   localparam logic [1:0] SNOOZE  = 2'd2;

endpackage

// File: rtl/alarm_trigger_if.sv
// Bundle of time, control and status signals between the timekeeping core,
// the alarm trigger and the LED/buzzer output blocks.
interface alarm_trigger_if;
   import alarm_pkg::*;

   logic              tick_1hz;
   logic [HOUR_W-1:0] cur_hour;
   logic [MIN_W-1:0]  cur_min;
   logic [HOUR_W-1:0] alarm_hour;
   logic [MIN_W-1:0]  alarm_min;
   logic              alarm_en;
   logic              stop_btn;
   logic              snooze_btn;
   logic              blink_signal;
   logic              ringing;
   logic              snoozing;
   logic [1:0]        snooze_count;

   modport master (
      output tick_1hz, cur_hour, cur_min, alarm_hour, alarm_min,
             alarm_en, stop_btn, snooze_btn,
      input  blink_signal, ringing, snoozing, snooze_count
   );

   modport slave (
      input  tick_1hz, cur_hour, cur_min, alarm_hour, alarm_min,
             alarm_en, stop_btn, snooze_btn,
      output blink_signal, ringing, snoozing, snooze_count
   );

endinterface

// File: rtl/rise_detect.sv
// One-bit rising-edge detector. The history register resets to RESET_VAL so a
// level already high when reset releases is not seen as an edge.
module rise_detect #(
   parameter logic RESET_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic rise
);

   logic prev_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prev_reg <= RESET_VAL;
      end else begin
         prev_reg <= d;
      end
   end

   assign rise = d & ~prev_reg;

endmodule

// File: rtl/alarm_trigger.sv
// Alarm FSM: fires on a rising edge of the time match, then handles stop,
// bounded snooze and ring timeout, all paced by the 1 Hz tick.
module alarm_trigger
   import alarm_pkg::*;
#(
   parameter int RING_TIMEOUT_SEC = 60,
   parameter int SNOOZE_SEC       = 300,
   parameter int MAX_SNOOZES      = 3
) (
   input logic             clk,
   input logic             rst_n,
   alarm_trigger_if.slave  bus
);

   localparam int SEC_MAX = (RING_TIMEOUT_SEC > SNOOZE_SEC) ? RING_TIMEOUT_SEC : SNOOZE_SEC;
   localparam int SEC_W   = $clog2(SEC_MAX + 1);

   // Terminal values are one below the limit: the tick that would reach the
   // limit triggers the transition instead of being stored.
   localparam logic [SEC_W-1:0] RING_LAST   = SEC_W'(RING_TIMEOUT_SEC - 1);
   localparam logic [SEC_W-1:0] SNOOZE_LAST = SEC_W'(SNOOZE_SEC - 1);
   localparam logic [1:0]       SNOOZE_MAX  = 2'(MAX_SNOOZES);

   localparam int EDGE_N = 3;

   logic              match;
   logic [EDGE_N-1:0] edge_in;
   logic [EDGE_N-1:0] edge_rise;
   logic              trigger;
   logic              stop_rise;
   logic              snooze_rise;

   state_t            state_reg, state_next;
   logic [SEC_W-1:0]  sec_cnt_reg, sec_cnt_next;
   logic [1:0]        snooze_count_reg, snooze_count_next;
   logic              ringing_reg;
   logic              snoozing_reg;
   logic              blink_reg;

   assign match = bus.alarm_en
                & (bus.cur_hour == bus.alarm_hour)
                & (bus.cur_min  == bus.alarm_min);

   assign edge_in = {bus.snooze_btn, bus.stop_btn, match};

   generate
      for (genvar gi = 0; gi < EDGE_N; gi++) begin : g_edge
         rise_detect #(
            .RESET_VAL (1'b1)
         ) u_rise (
            .clk   (clk),
            .rst_n (rst_n),
            .d     (edge_in[gi]),
            .rise  (edge_rise[gi])
         );
      end
   endgenerate

   assign trigger     = edge_rise[0];
   assign stop_rise   = edge_rise[1];
   assign snooze_rise = edge_rise[2];

   always_comb begin
      state_next        = state_reg;
      sec_cnt_next      = sec_cnt_reg;
      snooze_count_next = snooze_count_reg;

      case (state_reg)
         IDLE: begin
            if (trigger) begin
               state_next        = RINGING;
               snooze_count_next = 2'd0;
            end
         end

         RINGING: begin
            if (!bus.alarm_en || stop_rise) begin
               state_next = IDLE;
            end else if (snooze_rise && (snooze_count_reg < SNOOZE_MAX)) begin
               state_next        = SNOOZE;
               snooze_count_next = snooze_count_reg + 2'd1;
            end else if (bus.tick_1hz) begin
               if (sec_cnt_reg == RING_LAST) begin
                  state_next = IDLE;
               end else begin
                  sec_cnt_next = sec_cnt_reg + 1'b1;
               end
            end
         end

         SNOOZE: begin
            if (!bus.alarm_en || stop_rise) begin
               state_next = IDLE;
            end else if (bus.tick_1hz) begin
               if (sec_cnt_reg == SNOOZE_LAST) begin
                  state_next = RINGING;
               end else begin
                  sec_cnt_next = sec_cnt_reg + 1'b1;
               end
            end
         end

         default: begin
            state_next = IDLE;
         end
      endcase

      // Every state entry starts a fresh seconds count.
      if (state_next != state_reg) begin
         sec_cnt_next = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg        <= IDLE;
         sec_cnt_reg      <= '0;
         snooze_count_reg <= 2'd0;
         ringing_reg      <= 1'b0;
         snoozing_reg     <= 1'b0;
         blink_reg        <= 1'b0;
      end else begin
         state_reg        <= state_next;
         sec_cnt_reg      <= sec_cnt_next;
         snooze_count_reg <= snooze_count_next;
         ringing_reg      <= (state_next == RINGING);
         snoozing_reg     <= (state_next == SNOOZE);
         blink_reg        <= (state_next == RINGING);
      end
   end

   assign bus.ringing      = ringing_reg;
   assign bus.snoozing     = snoozing_reg;
   assign bus.blink_signal = blink_reg;
   assign bus.snooze_count = snooze_count_reg;

endmodule

// File: tb/tb_alarm_trigger.sv
// Directed bench for alarm_trigger: a countdown-based behavioural model checked
// every cycle, plus literal expectations at key points of each scenario.
module tb_alarm_trigger;

   localparam int RT = 4;
   localparam int SS = 3;
   localparam int MX = 2;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   always #10 clk = ~clk;

   alarm_trigger_if bus();

   alarm_trigger #(
      .RING_TIMEOUT_SEC (RT),
      .SNOOZE_SEC       (SS),
      .MAX_SNOOZES      (MX)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int chk_cnt  = 0;
   int pass_cnt = 0;

   task automatic check(input string name, input int act, input int exp);
      chk_cnt++;
      if (act == exp) pass_cnt++;
      else $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, exp, $time);
   endtask

   // Model: mode plus a countdown of seconds left in the current mode.
   typedef enum int {M_IDLE, M_RING, M_SNOOZE} mode_e;
   mode_e m_mode = M_IDLE;
   int    m_left = 0;
   int    m_cnt  = 0;
   bit    m_pm = 1'b1, m_ps = 1'b1, m_pz = 1'b1;

   initial begin : model
      bit m, trig, st, sz;
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            m_mode = M_IDLE; m_left = 0; m_cnt = 0;
            m_pm = 1'b1; m_ps = 1'b1; m_pz = 1'b1;
         end else begin
            m    = bus.alarm_en && (bus.cur_hour == bus.alarm_hour) && (bus.cur_min == bus.alarm_min);
            trig = m && !m_pm;
            st   = bus.stop_btn && !m_ps;
            sz   = bus.snooze_btn && !m_pz;
            m_pm = m; m_ps = bus.stop_btn; m_pz = bus.snooze_btn;
            if (m_mode == M_IDLE) begin
               if (trig) begin m_mode = M_RING; m_left = RT; m_cnt = 0; end
            end else if (!bus.alarm_en || st) begin
               m_mode = M_IDLE;
            end else if (m_mode == M_RING) begin
               if (sz && m_cnt < MX) begin
                  m_mode = M_SNOOZE; m_left = SS; m_cnt++;
               end else if (bus.tick_1hz) begin
                  m_left--;
                  if (m_left == 0) m_mode = M_IDLE;
               end
            end else if (bus.tick_1hz) begin
               m_left--;
               if (m_left == 0) begin m_mode = M_RING; m_left = RT; end
            end
         end
      end
   end

   initial begin : compare
      forever begin
         @(negedge clk);
         check("cyc_ringing",  int'(bus.ringing),      int'(m_mode == M_RING));
         check("cyc_blink",    int'(bus.blink_signal), int'(m_mode == M_RING));
         check("cyc_snoozing", int'(bus.snoozing),     int'(m_mode == M_SNOOZE));
         check("cyc_count",    int'(bus.snooze_count), m_cnt);
      end
   end

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog: got timeout, expected $finish");
      $fatal(1, "bench timed out");
   end

   task automatic cyc(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic pulse_stop();
      bus.stop_btn = 1'b1; cyc(1); bus.stop_btn = 1'b0;
   endtask

   task automatic pulse_snz();
      bus.snooze_btn = 1'b1; cyc(1); bus.snooze_btn = 1'b0;
   endtask

   task automatic do_tick();
      bus.tick_1hz = 1'b1; cyc(1); bus.tick_1hz = 1'b0;
   endtask

   task automatic retrigger();
      bus.cur_min = 6'd31; cyc(1); bus.cur_min = 6'd30; cyc(1);
   endtask

   initial begin : stim
      bus.tick_1hz   = 1'b0;
      bus.cur_hour   = 5'd7;
      bus.cur_min    = 6'd30;
      bus.alarm_hour = 5'd7;
      bus.alarm_min  = 6'd30;
      bus.alarm_en   = 1'b1;
      bus.stop_btn   = 1'b1;
      bus.snooze_btn = 1'b0;

      cyc(3);
      check("rst_ringing",  int'(bus.ringing), 0);
      check("rst_blink",    int'(bus.blink_signal), 0);
      check("rst_snoozing", int'(bus.snoozing), 0);
      check("rst_count",    int'(bus.snooze_count), 0);

      // Release in the matching minute with stop held: no fire.
      rst_n = 1'b1;
      cyc(3);
      check("rel_no_fire", int'(bus.ringing), 0);
      bus.stop_btn = 1'b0;
      cyc(2);
      check("rel_still_idle", int'(bus.ringing), 0);

      // Trigger and stop.
      bus.cur_min = 6'd29; cyc(1);
      bus.cur_min = 6'd30;
      check("pre_trig", int'(bus.ringing), 0);
      cyc(1);
      check("trig_ringing", int'(bus.ringing), 1);
      check("trig_blink",   int'(bus.blink_signal), 1);
      check("model_trig",   int'(m_mode == M_RING), 1);
      pulse_stop();
      check("stop_ringing",  int'(bus.ringing), 0);
      check("stop_blink",    int'(bus.blink_signal), 0);
      check("stop_snoozing", int'(bus.snoozing), 0);
      check("stop_count",    int'(bus.snooze_count), 0);

      // Timeout after RT ticks.
      retrigger();
      for (int i = 0; i < RT - 1; i++) begin
         do_tick();
         check("timeout_hold", int'(bus.ringing), 1);
      end
      do_tick();
      check("timeout_idle", int'(bus.ringing), 0);
      check("model_timeout", int'(m_mode == M_IDLE), 1);

      // Snooze limit.
      retrigger();
      pulse_snz();
      check("snz1_snoozing", int'(bus.snoozing), 1);
      check("snz1_ringing",  int'(bus.ringing), 0);
      check("snz1_count",    int'(bus.snooze_count), 1);
      do_tick(); do_tick();
      check("snz1_hold", int'(bus.snoozing), 1);
      do_tick();
      check("snz1_back_ring", int'(bus.ringing), 1);
      check("snz1_keep_count", int'(bus.snooze_count), 1);
      pulse_snz();
      check("snz2_count", int'(bus.snooze_count), 2);
      check("model_snz2", m_cnt, 2);
      for (int i = 0; i < SS; i++) do_tick();
      check("snz2_back_ring", int'(bus.ringing), 1);
      pulse_snz();
      check("snz3_ignored_ring", int'(bus.ringing), 1);
      check("snz3_ignored_snz",  int'(bus.snoozing), 0);
      check("snz3_count",        int'(bus.snooze_count), 2);
      pulse_stop();
      check("idle_hold_count", int'(bus.snooze_count), 2);

      // Simultaneous events.
      retrigger();
      check("retrig_clear_count", int'(bus.snooze_count), 0);
      bus.stop_btn = 1'b1; bus.snooze_btn = 1'b1; cyc(1);
      bus.stop_btn = 1'b0; bus.snooze_btn = 1'b0;
      check("stop_snz_ringing",  int'(bus.ringing), 0);
      check("stop_snz_snoozing", int'(bus.snoozing), 0);
      retrigger();
      for (int i = 0; i < RT - 1; i++) do_tick();
      bus.tick_1hz = 1'b1; bus.snooze_btn = 1'b1; cyc(1);
      bus.tick_1hz = 1'b0; bus.snooze_btn = 1'b0;
      check("tick_snz_snoozing", int'(bus.snoozing), 1);
      check("tick_snz_count",    int'(bus.snooze_count), 1);
      pulse_stop();
      retrigger();
      bus.alarm_en = 1'b0; bus.snooze_btn = 1'b1; cyc(1);
      bus.snooze_btn = 1'b0;
      check("en_snz_ringing",  int'(bus.ringing), 0);
      check("en_snz_snoozing", int'(bus.snoozing), 0);
      bus.cur_min = 6'd31; bus.alarm_en = 1'b1; cyc(2);

      // Asynchronous reset mid-snooze.
      bus.cur_min = 6'd30; cyc(1);
      pulse_snz();
      cyc(1);
      check("pre_rst_snoozing", int'(bus.snoozing), 1);
      #2 rst_n = 1'b0;
      #1;
      check("async_snoozing", int'(bus.snoozing), 0);
      check("async_ringing",  int'(bus.ringing), 0);
      check("async_blink",    int'(bus.blink_signal), 0);
      check("async_count",    int'(bus.snooze_count), 0);
      cyc(1);
      rst_n = 1'b1;
      cyc(3);
      check("post_rst_idle", int'(bus.ringing), 0);
      retrigger();
      check("next_day_ring", int'(bus.ringing), 1);
      pulse_stop();

      // Arming inside the matching minute.
      bus.alarm_en = 1'b0; cyc(2);
      bus.alarm_en = 1'b1; cyc(1);
      check("arm_in_minute", int'(bus.ringing), 1);
      pulse_stop();
      cyc(3);
      check("no_refire", int'(bus.ringing), 0);

      cyc(2);
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
